// File: rtl/seq_shift_unit.sv
// Iterative 8-bit shifter/rotator for the ALU path: one bit position per clock,
// with a start/busy/done handshake and a registered zero flag.
module seq_shift_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [CNT_W-1:0] AMOUNT,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ZERO,
  output logic             ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  localparam logic [CNT_W-1:0] MAX_N    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ROT_MASK = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] n_calc;
  logic             op_bad;
  logic [WIDTH-1:0] step;
  logic             accept;

  // Iteration count: shifts saturate at WIDTH, rotates wrap modulo WIDTH.
  always_comb begin
    op_bad = 1'b0;
    n_calc = '0;
    case (OP)
      OP_SLL, OP_SRL, OP_SRA: n_calc = (AMOUNT > MAX_N) ? MAX_N : AMOUNT;
      OP_ROR, OP_ROL:         n_calc = AMOUNT & ROT_MASK;
      default:                op_bad = 1'b1;
    endcase
  end

  always_comb begin
    step = RESULT;
    case (op_q)
      OP_SLL:  step = {RESULT[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, RESULT[WIDTH-1:1]};
      OP_SRA:  step = {RESULT[WIDTH-1], RESULT[WIDTH-1:1]};
      OP_ROR:  step = {RESULT[0], RESULT[WIDTH-1:1]};
      OP_ROL:  step = {RESULT[WIDTH-2:0], RESULT[WIDTH-1]};
      default: step = RESULT;
    endcase
  end

  assign accept = START && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      op_q   <= '0;
      count  <= '0;
      RESULT <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      ZERO   <= 1'b0;
      ERR    <= 1'b0;
    end else if (accept) begin
      op_q   <= OP;
      count  <= n_calc;
      RESULT <= DATA1;
      ZERO   <= (DATA1 == '0);
      ERR    <= op_bad;
      // A zero-length operation completes straight away with no BUSY cycle.
      if (n_calc != '0) begin
        state <= ST_SHIFT;
        BUSY  <= 1'b1;
        DONE  <= 1'b0;
      end else begin
        state <= ST_DONE;
        BUSY  <= 1'b0;
        DONE  <= 1'b1;
      end
    end else begin
      case (state)
        ST_SHIFT: begin
          RESULT <= step;
          ZERO   <= (step == '0);
          count  <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          DONE  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: a transaction-level model checked every cycle,
// plus hand-computed results and BUSY lengths for each directed operation.
module tb_seq_shift_unit;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START = 1'b0;
  logic [2:0] OP = 3'b000;
  logic [7:0] DATA1 = 8'h00;
  logic [3:0] AMOUNT = 4'h0;
  logic [7:0] RESULT;
  logic       BUSY, DONE, ZERO, ERR;

  int tests_run = 0;
  int tests_failed = 0;

  seq_shift_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP), .DATA1(DATA1),
    .AMOUNT(AMOUNT), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE), .ZERO(ZERO), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference result straight from the operation definitions.
  function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] d, input int amt);
    int r;
    logic [15:0] w;
    case (op)
      3'd0: return (amt >= 8) ? 8'h00 : 8'((16'(d) << amt) & 16'hFF);
      3'd1: return (amt >= 8) ? 8'h00 : 8'(d >> amt);
      3'd2: begin
        if (amt >= 8) return {8{d[7]}};
        w = {{8{d[7]}}, d} >> amt;
        return w[7:0];
      end
      3'd3: begin
        r = amt % 8;
        w = {d, d} >> r;
        return w[7:0];
      end
      3'd4: begin
        r = amt % 8;
        w = {d, d} << r;
        return w[15:8];
      end
      default: return d;
    endcase
  endfunction

  function automatic int ref_iters(input logic [2:0] op, input int amt);
    if (op <= 3'd2) return (amt > 8) ? 8 : amt;
    if (op <= 3'd4) return amt % 8;
    return 0;
  endfunction

  // Transaction model: remembers the edge index of the last accept and its outcome.
  int         cyc = 0;
  bit         active = 0;
  int         acc_edge = 0;
  int         exp_n = 0;
  logic [7:0] exp_res = 8'h00;
  bit         exp_err = 0;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      active = 0;
    end else begin
      cyc = cyc + 1;
      if (START && (!active || (cyc - 1 >= acc_edge + exp_n))) begin
        active   = 1;
        acc_edge = cyc;
        exp_n    = ref_iters(OP, int'(AMOUNT));
        exp_res  = ref_result(OP, DATA1, int'(AMOUNT));
        exp_err  = (OP > 3'd4);
      end
    end
  end

  always @(negedge CLK) begin
    if (!RESET_N || !active) begin
      check("idle_result", int'(RESULT), 0);
      check("idle_busy", int'(BUSY), 0);
      check("idle_done", int'(DONE), 0);
      check("idle_zero", int'(ZERO), 0);
      check("idle_err", int'(ERR), 0);
    end else begin
      check("busy", int'(BUSY), int'(cyc >= acc_edge && cyc < acc_edge + exp_n));
      check("done", int'(DONE), int'(cyc == acc_edge + exp_n));
      check("err", int'(ERR), int'(exp_err));
      if (cyc >= acc_edge + exp_n) begin
        check("result", int'(RESULT), int'(exp_res));
        check("zero", int'(ZERO), int'(exp_res == 8'h00));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic [3:0] amt);
    @(posedge CLK);
    #1;
    START = 1'b1; OP = op; DATA1 = d; AMOUNT = amt;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Waits for DONE, counting BUSY cycles, then pins result and BUSY length to literals.
  task automatic wait_done(input string name, input logic [7:0] lit_res, input int lit_busy,
                           input bit lit_err);
    int  nbusy = 0;
    bit  seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE) begin
        seen = 1;
        break;
      end
      if (BUSY) nbusy++;
    end
    check({name, "_done_seen"}, int'(seen), 1);
    if (seen) begin
      check({name, "_lit_result"}, int'(RESULT), int'(lit_res));
      check({name, "_lit_err"}, int'(ERR), int'(lit_err));
      if (lit_busy >= 0) check({name, "_lit_busy"}, nbusy, lit_busy);
    end
    $display("[TB] %s: RESULT=0x%02h ZERO=%0d ERR=%0d busy_cycles=%0d", name, RESULT, ZERO, ERR, nbusy);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (2) @(posedge CLK);

    issue(3'd0, 8'h81, 4'd1);  wait_done("sll_81_1", 8'h02, 1, 0);
    issue(3'd2, 8'h90, 4'd3);  wait_done("sra_90_3", 8'hF2, 3, 0);
    issue(3'd2, 8'h80, 4'd12); wait_done("sra_80_12", 8'hFF, 8, 0);
    issue(3'd4, 8'h81, 4'd1);  wait_done("rol_81_1", 8'h03, 1, 0);
    issue(3'd3, 8'h01, 4'd9);  wait_done("ror_01_9", 8'h80, 1, 0);
    issue(3'd3, 8'h5A, 4'd8);  wait_done("ror_5a_8", 8'h5A, 0, 0);
    issue(3'd4, 8'hB1, 4'd3);  wait_done("rol_b1_3", 8'h8D, 3, 0);

    issue(3'd1, 8'hFF, 4'd8);  wait_done("srl_ff_8", 8'h00, 8, 0);
    check("srl_ff_8_zero", int'(ZERO), 1);
    // Back-to-back issue while DONE is high.
    START = 1'b1; OP = 3'd0; DATA1 = 8'h01; AMOUNT = 4'd2;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_done("b2b_sll_01_2", 8'h04, 2, 0);

    // START pulsed during SHIFT must be ignored.
    issue(3'd0, 8'h0F, 4'd6);
    @(posedge CLK);
    #1 START = 1'b1; OP = 3'd1; DATA1 = 8'hAA; AMOUNT = 4'd1;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_done("sll_0f_6_ignore", 8'hC0, -1, 0);

    // Asynchronous reset in the middle of an operation.
    issue(3'd1, 8'hF0, 4'd5);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b0;
    #1;
    check("rst_result", int'(RESULT), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_done", int'(DONE), 0);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (6) @(posedge CLK);
    issue(3'd1, 8'hF0, 4'd5);  wait_done("srl_f0_5_after_rst", 8'h07, 5, 0);

    issue(3'd7, 8'h3C, 4'd3);  wait_done("invalid_op", 8'h3C, 0, 1);
    issue(3'd1, 8'h3C, 4'd2);  wait_done("srl_3c_2_clears_err", 8'h0F, 2, 0);

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
